// File: rtl/paam_pkg.sv
// Shared definitions for the paam_err_monitor error-metric collector.
// Optional feature macro used across this slice: PAAM_MON_BIAS_EN.
package paam_pkg;

    localparam int A_W = 8;
    localparam int B_W = 6;
    localparam int P_W = 14;

    // Largest exact product of the 8x6 multiplier (255 * 63).
    localparam int MAX_EXACT = 16065;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned absolute difference of two product-width values.
    function automatic logic [P_W-1:0] abs_diff(input logic [P_W-1:0] x,
                                                input logic [P_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/paam_err_dist.sv
// Combinational exact product and error distance for one sample.
// With PAAM_MON_BIAS_EN defined it also provides the signed error p - exact.
module paam_err_dist
    import paam_pkg::*;
(
    input  logic [A_W-1:0]        a,
    input  logic [B_W-1:0]        b,
    input  logic [P_W-1:0]        p,
    output logic [P_W-1:0]        exact,
    output logic [P_W-1:0]        ed
`ifdef PAAM_MON_BIAS_EN
    ,
    output logic signed [P_W:0]   diff
`endif
);

    // Exact product never exceeds MAX_EXACT, so P_W bits always hold it.
    always_comb begin
        exact = P_W'(a) * P_W'(b);
        ed    = abs_diff(exact, p);
`ifdef PAAM_MON_BIAS_EN
        diff  = $signed({1'b0, p}) - $signed({1'b0, exact});
`endif
    end

endmodule

// File: rtl/paam_err_monitor.sv
// Streaming error-metric collector for the 8x6 approximate multiplier.
// Accumulates error-distance sum, maximum and erroneous-sample count over a
// run of N_SAMPLES samples and presents them on a valid/ready result port.
// Optional feature macro: PAAM_MON_BIAS_EN adds the signed bias_sum output.
module paam_err_monitor
    import paam_pkg::*;
#(
    parameter int N_SAMPLES = 256,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1),
    parameter int SUM_W     = P_W + CNT_W
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [A_W-1:0]          in_a,
    input  logic [B_W-1:0]          in_b,
    input  logic [P_W-1:0]          in_p,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SUM_W-1:0]        sum_ed,
    output logic [P_W-1:0]          max_ed,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    busy
`ifdef PAAM_MON_BIAS_EN
    ,
    output logic signed [SUM_W:0]   bias_sum
`endif
);

    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

    state_t             state;
    state_t             state_next;
    logic               run_start;
    logic               accept;
    logic [CNT_W-1:0]   acc_cnt;

    logic               s1_valid;
    logic [A_W-1:0]     s1_a;
    logic [B_W-1:0]     s1_b;
    logic [P_W-1:0]     s1_p;

    logic               s2_valid;
    logic [P_W-1:0]     s2_ed;

    logic [P_W-1:0]     dist_exact;
    logic [P_W-1:0]     dist_ed;
`ifdef PAAM_MON_BIAS_EN
    logic signed [P_W:0] dist_diff;
    logic signed [P_W:0] s2_diff;
`endif

    assign accept = in_valid && in_ready;

    // Next-state and handshake decode; in FLUSH the S2 register drains on the
    // same edge that enters DONE, so results are final when out_valid rises.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        run_start  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    run_start  = 1'b1;
                end
            end
            RUN: begin
                in_ready = (acc_cnt < N_LAST);
                if (in_valid && in_ready && (acc_cnt == N_LAST - CNT_W'(1))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!s1_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accept counter: cleared when a run starts, stalls through in_valid gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (run_start) begin
            acc_cnt <= '0;
        end else if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    // Stage S1: capture the accepted operands and approximate product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_p     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= in_a;
                s1_b <= in_b;
                s1_p <= in_p;
            end
        end
    end

    paam_err_dist u_dist (
        .a     (s1_a),
        .b     (s1_b),
        .p     (s1_p),
        .exact (dist_exact),
        .ed    (dist_ed)
`ifdef PAAM_MON_BIAS_EN
        ,
        .diff  (dist_diff)
`endif
    );

    // Stage S2: register the error distance of the sample held in S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_ed    <= '0;
`ifdef PAAM_MON_BIAS_EN
            s2_diff  <= '0;
`endif
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_ed   <= dist_ed;
`ifdef PAAM_MON_BIAS_EN
                s2_diff <= dist_diff;
`endif
            end
        end
    end

    // Statistics accumulators: cleared at run start, fed by S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (run_start) begin
            sum_ed  <= '0;
            max_ed  <= '0;
            err_cnt <= '0;
        end else if (s2_valid) begin
            sum_ed <= sum_ed + SUM_W'(s2_ed);
            if (s2_ed > max_ed) begin
                max_ed <= s2_ed;
            end
            if (s2_ed != '0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef PAAM_MON_BIAS_EN
    // Signed bias accumulator; the per-sample difference is sign-extended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_sum <= '0;
        end else if (run_start) begin
            bias_sum <= '0;
        end else if (s2_valid) begin
            bias_sum <= bias_sum + $signed({{(SUM_W - P_W){s2_diff[P_W]}}, s2_diff});
        end
    end
`endif

endmodule

// File: tb/tb_paam_err_monitor.sv
// Self-checking bench for paam_err_monitor: three instances (N_SAMPLES = 1, 4
// and 8) share the sample bus; each has its own start. Directed vectors with
// hand-computed expectations. Honours PAAM_MON_BIAS_EN for bias_sum.
module tb_paam_err_monitor;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [7:0]  in_a;
    logic [5:0]  in_b;
    logic [13:0] in_p;
    logic out_ready;
    logic start1, start4, start8;

    logic in_ready1, out_valid1, busy1;
    logic [14:0] sum1;
    logic [13:0] max1;
    logic [0:0]  err1;
    logic in_ready4, out_valid4, busy4;
    logic [16:0] sum4;
    logic [13:0] max4;
    logic [2:0]  err4;
    logic in_ready8, out_valid8, busy8;
    logic [17:0] sum8;
    logic [13:0] max8;
    logic [3:0]  err8;
`ifdef PAAM_MON_BIAS_EN
    logic signed [15:0] bias1;
    logic signed [17:0] bias4;
    logic signed [18:0] bias8;
`endif

    int checks = 0;
    int errors = 0;
    int acc1 = 0;
    int acc4 = 0;
    int acc8 = 0;

    typedef struct {
        logic [7:0]  a;
        logic [5:0]  b;
        logic [13:0] p;
    } sample_t;

    typedef struct {
        int sum_e;
        int max_e;
        int err_e;
        int bias_e;
    } result_t;

    sample_t samp[16];
    result_t res[4];

    always #5 clk = ~clk;

    paam_err_monitor #(.N_SAMPLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid),
        .in_ready(in_ready1), .in_a(in_a), .in_b(in_b), .in_p(in_p),
        .out_valid(out_valid1), .out_ready(out_ready), .sum_ed(sum1),
        .max_ed(max1), .err_cnt(err1), .busy(busy1)
`ifdef PAAM_MON_BIAS_EN
        , .bias_sum(bias1)
`endif
    );

    paam_err_monitor #(.N_SAMPLES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid),
        .in_ready(in_ready4), .in_a(in_a), .in_b(in_b), .in_p(in_p),
        .out_valid(out_valid4), .out_ready(out_ready), .sum_ed(sum4),
        .max_ed(max4), .err_cnt(err4), .busy(busy4)
`ifdef PAAM_MON_BIAS_EN
        , .bias_sum(bias4)
`endif
    );

    paam_err_monitor #(.N_SAMPLES(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(in_valid),
        .in_ready(in_ready8), .in_a(in_a), .in_b(in_b), .in_p(in_p),
        .out_valid(out_valid8), .out_ready(out_ready), .sum_ed(sum8),
        .max_ed(max8), .err_cnt(err8), .busy(busy8)
`ifdef PAAM_MON_BIAS_EN
        , .bias_sum(bias8)
`endif
    );

    // Count handshakes seen by each instance at the active edge.
    always @(posedge clk) begin
        if (in_valid && in_ready1) acc1++;
        if (in_valid && in_ready4) acc4++;
        if (in_valid && in_ready8) acc8++;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input sample_t s, input int gap);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        in_valid = 1'b1;
        in_a = s.a;
        in_b = s.b;
        in_p = s.p;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic getOutValid(input int which);
        case (which)
            1:       return out_valid1;
            4:       return out_valid4;
            default: return out_valid8;
        endcase
    endfunction

    task automatic waitOut(input int which, input string name);
        int n = 0;
        while (!getOutValid(which) && n < 50) begin
            tick();
            n++;
        end
        checkOutput(name, int'(getOutValid(which)), 1);
    endtask

    initial begin
        int sum_hold;

        samp[0]  = '{8'd255, 6'd63, 14'd16383};
        samp[1]  = '{8'd3,   6'd5,  14'd15};
        samp[2]  = '{8'd10,  6'd10, 14'd100};
        samp[3]  = '{8'd1,   6'd1,  14'd0};
        res[0]   = '{319, 318, 2, 317};
        samp[4]  = '{8'd0,   6'd0,  14'd0};
        samp[5]  = '{8'd1,   6'd1,  14'd1};
        samp[6]  = '{8'd2,   6'd3,  14'd6};
        samp[7]  = '{8'd255, 6'd63, 14'd16065};
        res[1]   = '{0, 0, 0, 0};
        samp[8]  = '{8'd2,   6'd2,  14'd7};
        samp[9]  = '{8'd2,   6'd2,  14'd1};
        samp[10] = '{8'd0,   6'd0,  14'd0};
        samp[11] = '{8'd0,   6'd0,  14'd0};
        res[2]   = '{6, 3, 2, 0};
        samp[12] = '{8'd0,   6'd0,  14'd16383};
        samp[13] = '{8'd255, 6'd63, 14'd0};
        samp[14] = '{8'd100, 6'd50, 14'd5000};
        samp[15] = '{8'd7,   6'd9,  14'd60};
        res[3]   = '{32451, 16383, 3, 315};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_p = '0;
        out_ready = 1'b0;
        start1 = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;

        // Reset values.
        tick();
        tick();
        checkOutput("reset_in_ready", int'(in_ready4), 0);
        checkOutput("reset_out_valid", int'(out_valid4), 0);
        checkOutput("reset_busy", int'(busy4), 0);
        checkOutput("reset_sum_ed", int'(sum4), 0);
        checkOutput("reset_max_ed", int'(max4), 0);
        checkOutput("reset_err_cnt", int'(err4), 0);
`ifdef PAAM_MON_BIAS_EN
        checkOutput("reset_bias_sum", int'(bias4), 0);
`endif
        rst_n = 1'b1;
        tick();

        // in_valid while every instance is idle must not be consumed.
        in_valid = 1'b1;
        in_p = 14'd99;
        tick();
        tick();
        tick();
        checkOutput("idle_in_ready", int'(in_ready4), 0);
        checkOutput("idle_accepts", acc1 + acc4 + acc8, 0);
        checkOutput("idle_err_cnt", int'(err4), 0);
        checkOutput("idle_sum_ed", int'(sum4), 0);
        in_valid = 1'b0;

        // N_SAMPLES = 1: exact result timing.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput("n1_in_ready_latency", int'(in_ready1), 1);
        applyStimulus('{8'd0, 6'd0, 14'd63}, 0);
        checkOutput("n1_in_ready_after_accept", int'(in_ready1), 0);
        checkOutput("n1_out_valid_edge0", int'(out_valid1), 0);
        tick();
        checkOutput("n1_out_valid_edge1", int'(out_valid1), 0);
        tick();
        checkOutput("n1_out_valid_edge2", int'(out_valid1), 1);
        checkOutput("n1_sum_ed", int'(sum1), 63);
        checkOutput("n1_max_ed", int'(max1), 63);
        checkOutput("n1_err_cnt", int'(err1), 1);
`ifdef PAAM_MON_BIAS_EN
        checkOutput("n1_bias_sum", int'(bias1), 63);
`endif
        checkOutput("n1_accepts", acc1, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("n1_out_valid_released", int'(out_valid1), 0);
        checkOutput("n1_busy_after", int'(busy1), 0);

        // N_SAMPLES = 4: table of runs.
        for (int r = 0; r < 4; r++) begin
            acc4 = 0;
            start4 = 1'b1;
            tick();
            start4 = 1'b0;
            checkOutput($sformatf("run%0d_in_ready_latency", r), int'(in_ready4), 1);
            for (int k = 0; k < 4; k++) begin
                if (r == 0 && k == 2) begin
                    start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                end
                applyStimulus(samp[r*4+k], ((r + k) % 3 == 0) ? 1 : 0);
            end
            checkOutput($sformatf("run%0d_in_ready_after_last", r), int'(in_ready4), 0);
            checkOutput($sformatf("run%0d_busy_flush", r), int'(busy4), 1);
            waitOut(4, $sformatf("run%0d_out_valid", r));
            checkOutput($sformatf("run%0d_sum_ed", r), int'(sum4), res[r].sum_e);
            checkOutput($sformatf("run%0d_max_ed", r), int'(max4), res[r].max_e);
            checkOutput($sformatf("run%0d_err_cnt", r), int'(err4), res[r].err_e);
`ifdef PAAM_MON_BIAS_EN
            checkOutput($sformatf("run%0d_bias_sum", r), int'(bias4), res[r].bias_e);
`endif
            checkOutput($sformatf("run%0d_accepts", r), acc4, 4);

            if (r == 0) begin
                // Output stall with a start pulse while in DONE.
                sum_hold = int'(sum4);
                for (int t = 0; t < 10; t++) begin
                    start4 = (t == 3);
                    tick();
                end
                start4 = 1'b0;
                checkOutput("stall_out_valid_held", int'(out_valid4), 1);
                checkOutput("stall_sum_ed_held", int'(sum4), sum_hold);
                checkOutput("stall_busy_held", int'(busy4), 1);
            end

            // Result handshake; run 1 also pulses start on the handshake edge.
            out_ready = 1'b1;
            start4 = (r == 1);
            tick();
            out_ready = 1'b0;
            start4 = 1'b0;
            checkOutput($sformatf("run%0d_out_valid_released", r), int'(out_valid4), 0);
            checkOutput($sformatf("run%0d_busy_after", r), int'(busy4), 0);
            if (r == 1) begin
                tick();
                checkOutput("handshake_start_ignored_busy", int'(busy4), 0);
                checkOutput("handshake_start_ignored_in_ready", int'(in_ready4), 0);
            end
        end

        // N_SAMPLES = 8: reset mid-run after 3 samples, then a clean run.
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 3; k++) applyStimulus('{8'd0, 6'd0, 14'd100}, 0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", int'(busy8), 0);
        checkOutput("midreset_in_ready", int'(in_ready8), 0);
        checkOutput("midreset_out_valid", int'(out_valid8), 0);
        checkOutput("midreset_sum_ed", int'(sum8), 0);
        checkOutput("midreset_err_cnt", int'(err8), 0);
        tick();
        rst_n = 1'b1;
        tick();
        acc8 = 0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus('{8'(i), 6'd2, 14'(2 * i + ((i % 2 == 1) ? 5 : 0))},
                          int'($urandom_range(0, 2)));
        end
        checkOutput("n8_in_ready_after_last", int'(in_ready8), 0);
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        waitOut(8, "n8_out_valid");
        checkOutput("n8_accepts", acc8, 8);
        checkOutput("n8_sum_ed", int'(sum8), 20);
        checkOutput("n8_max_ed", int'(max8), 5);
        checkOutput("n8_err_cnt", int'(err8), 4);
`ifdef PAAM_MON_BIAS_EN
        checkOutput("n8_bias_sum", int'(bias8), 20);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("n8_busy_after", int'(busy8), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
